// File: rtl/fetch_sequencer_if.sv
// Signals between the fetch sequencer and the PC, instruction memory, decoder and jump source.
interface fetch_sequencer_if #(parameter int WIDTH = 16);
  logic [WIDTH-1:0] pc_value;
  logic             pc_inc;
  logic             pc_load_bar;
  logic [WIDTH-1:0] bus_out;
  logic             bus_en;
  logic [WIDTH-1:0] mem_addr;
  logic             mem_req;
  logic             mem_ack;
  logic [WIDTH-1:0] mem_rdata;
  logic [WIDTH-1:0] instr;
  logic             instr_valid;
  logic             instr_ready;
  logic             jump_req;
  logic [WIDTH-1:0] jump_target;
  logic             jump_ack;
  logic             fault;

  modport master (
    input  pc_value, mem_ack, mem_rdata, instr_ready, jump_req, jump_target,
    output pc_inc, pc_load_bar, bus_out, bus_en, mem_addr, mem_req,
           instr, instr_valid, jump_ack, fault
  );

  modport slave (
    output pc_value, mem_ack, mem_rdata, instr_ready, jump_req, jump_target,
    input  pc_inc, pc_load_bar, bus_out, bus_en, mem_addr, mem_req,
           instr, instr_valid, jump_ack, fault
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: reads the word at the PC, advances the PC, hands the word to
// decode, and loads jump targets into the PC over the shared bus.
//
// state   | meaning
// FETCH   | sample PC (or accept a pending jump)
// WAIT    | memory read outstanding, timeout running
// INC     | pulse PC increment
// VALID   | instruction offered to decoder
// LOAD    | drive jump target on bus, strobe PC load
// FAULT   | memory never answered; held until reset
module fetch_sequencer #(
  parameter int WIDTH   = 16,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset_bar,
  fetch_sequencer_if.master port
);

  typedef enum logic [2:0] {
    S_FETCH, S_WAIT, S_INC, S_VALID, S_LOAD, S_FAULT
  } state_t;

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam bit TIMEOUT_EN = (TIMEOUT != 0);
  // Down-counter starts at TIMEOUT-1 so FAULT follows exactly TIMEOUT unanswered WAIT cycles.
  localparam logic [CW-1:0] TC_LOAD = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_t          state, state_next;
  logic [CW-1:0]   tmr;

  always_ff @(posedge clk) begin
    if (!reset_bar) state <= S_FETCH;
    else            state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_FETCH: state_next = port.jump_req ? S_LOAD : S_WAIT;
      S_WAIT: begin
        if (port.mem_ack)                    state_next = S_INC;
        else if (TIMEOUT_EN && tmr == '0)    state_next = S_FAULT;
      end
      S_INC:   state_next = S_VALID;
      S_VALID: begin
        if (port.jump_req)         state_next = S_LOAD;
        else if (port.instr_ready) state_next = S_FETCH;
      end
      S_LOAD:  state_next = S_FETCH;
      S_FAULT: state_next = S_FAULT;
      default: state_next = S_FETCH;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state register.
  always_ff @(posedge clk) begin
    if (!reset_bar) begin
      port.pc_inc      <= 1'b0;
      port.pc_load_bar <= 1'b1;
      port.bus_en      <= 1'b0;
      port.bus_out     <= '0;
      port.mem_req     <= 1'b0;
      port.mem_addr    <= '0;
      port.instr       <= '0;
      port.instr_valid <= 1'b0;
      port.jump_ack    <= 1'b0;
      port.fault       <= 1'b0;
      tmr              <= '0;
    end else begin
      port.pc_inc      <= (state_next == S_INC);
      port.pc_load_bar <= (state_next != S_LOAD);
      port.bus_en      <= (state_next == S_LOAD);
      port.jump_ack    <= (state_next == S_LOAD);
      port.mem_req     <= (state_next == S_WAIT);
      port.instr_valid <= (state_next == S_VALID);
      port.fault       <= (state_next == S_FAULT);
      port.bus_out     <= (state_next == S_LOAD) ? port.jump_target : '0;
      if (state == S_FETCH && state_next == S_WAIT) begin
        port.mem_addr <= port.pc_value;
        tmr           <= TC_LOAD;
      end else if (state == S_WAIT) begin
        if (port.mem_ack) begin
          port.instr <= port.mem_rdata;
          tmr        <= '0;
        end else if (tmr != '0) begin
          tmr <= tmr - 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: PC and memory models, a phase-level reference model compared every
// cycle, directed scenarios with literal expectations, then randomized traffic.
module tb_fetch_sequencer;
  localparam int W    = 16;
  localparam int TO_A = 255;
  localparam int P_FETCH = 0, P_WAIT = 1, P_INC = 2, P_VALID = 3, P_LOAD = 4, P_FAULT = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_bar, reset_bar_b;

  fetch_sequencer_if #(.WIDTH(W)) ifa ();
  fetch_sequencer_if #(.WIDTH(W)) ifb ();

  fetch_sequencer #(.WIDTH(W), .TIMEOUT(TO_A)) dut_a (.clk(clk), .reset_bar(reset_bar),   .port(ifa.master));
  fetch_sequencer #(.WIDTH(W), .TIMEOUT(4))    dut_b (.clk(clk), .reset_bar(reset_bar_b), .port(ifb.master));

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %h want %h", name, $time, act, exp);
    end
  endtask

  function automatic logic [W-1:0] memf(input logic [W-1:0] a);
    return {a[7:0], a[15:8]} ^ 16'h5A3C;
  endfunction

  // Reference model: which phase the sequencer is in and what it holds.
  int         m_ph = P_FETCH;
  int         m_waited = 0;
  logic [W-1:0] m_addr = '0, m_instr = '0, m_tgt = '0;
  bit         chk_en = 1'b0;

  always @(posedge clk) begin
    if (!reset_bar) begin
      m_ph = P_FETCH; m_addr = '0; m_instr = '0; m_tgt = '0; m_waited = 0;
    end else begin
      case (m_ph)
        P_FETCH:
          if (ifa.jump_req) begin m_tgt = ifa.jump_target; m_ph = P_LOAD; end
          else begin m_addr = ifa.pc_value; m_waited = 0; m_ph = P_WAIT; end
        P_WAIT:
          if (ifa.mem_ack) begin m_instr = ifa.mem_rdata; m_ph = P_INC; end
          else begin m_waited++; if (m_waited == TO_A) m_ph = P_FAULT; end
        P_INC:   m_ph = P_VALID;
        P_VALID:
          if (ifa.jump_req) begin m_tgt = ifa.jump_target; m_ph = P_LOAD; end
          else if (ifa.instr_ready) m_ph = P_FETCH;
        P_LOAD:  m_ph = P_FETCH;
        default: m_ph = m_ph;
      endcase
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      logic [54:0] act_v, exp_v;
      act_v = {ifa.pc_inc, ifa.pc_load_bar, ifa.bus_en, ifa.jump_ack, ifa.mem_req,
               ifa.instr_valid, ifa.fault, ifa.bus_out, ifa.mem_addr, ifa.instr};
      exp_v = {m_ph == P_INC, m_ph != P_LOAD, m_ph == P_LOAD, m_ph == P_LOAD, m_ph == P_WAIT,
               m_ph == P_VALID, m_ph == P_FAULT, (m_ph == P_LOAD) ? m_tgt : 16'h0, m_addr, m_instr};
      chk($sformatf("cycle_ph%0d", m_ph), {9'h0, act_v}, {9'h0, exp_v});
      if (ifa.instr_valid) chk("instr_vs_mem", ifa.instr, memf(ifa.mem_addr));
      chk("inc_with_load", ifa.pc_inc & ~ifa.pc_load_bar, 0);
    end
  end

  // Environment: PC, memory with per-request ack delay, jump release on ack.
  int delay_mode = 0;
  int mk = 0, md = 0;
  int inc_count = 0, jack_count = 0;

  task automatic tick();
    @(negedge clk);
    if (ifa.pc_inc === 1'b1) begin ifa.pc_value = ifa.pc_value + 1'b1; inc_count++; end
    if (ifa.pc_load_bar === 1'b0) ifa.pc_value = ifa.bus_out;
    if (ifa.mem_req === 1'b1) begin
      ifa.mem_ack = (mk == md);
      mk++;
    end else begin
      ifa.mem_ack = 1'b0;
      mk = 0;
      md = (delay_mode < 0) ? int'($urandom_range(0, 6)) : delay_mode;
    end
    ifa.mem_rdata = memf(ifa.mem_addr);
    if (ifa.jump_ack === 1'b1) begin ifa.jump_req = 1'b0; jack_count++; end
  endtask

  initial begin
    int incs0, jc0, inc_at, ack_at;
    reset_bar = 1'b0; reset_bar_b = 1'b0;
    ifa.pc_value = 16'd1500; ifa.mem_ack = 1'b0; ifa.mem_rdata = '0;
    ifa.instr_ready = 1'b0; ifa.jump_req = 1'b0; ifa.jump_target = '0;
    ifb.pc_value = 16'h0100; ifb.mem_ack = 1'b0; ifb.mem_rdata = '0;
    ifb.instr_ready = 1'b0; ifb.jump_req = 1'b0; ifb.jump_target = '0;
    delay_mode = 0;
    repeat (3) tick();
    chk_en = 1'b1;
    chk("rst_pc_load_bar", ifa.pc_load_bar, 1);
    chk("rst_mem_req", ifa.mem_req, 0);

    // 1: immediate ack after reset
    reset_bar = 1'b1;
    tick();
    chk("t1_req", ifa.mem_req, 1);
    chk("t1_addr", ifa.mem_addr, 1500);
    tick();
    chk("t1_inc", ifa.pc_inc, 1);
    chk("t1_instr", ifa.instr, 16'h8639);
    tick();
    chk("t1_valid", ifa.instr_valid, 1);
    repeat (2) tick();
    chk("t1_valid_hold", ifa.instr_valid, 1);
    chk("t1_pc", ifa.pc_value, 1501);

    // 2: ack delayed 5 cycles
    delay_mode = 5; ifa.instr_ready = 1'b1;
    tick();
    ifa.instr_ready = 1'b0;
    incs0 = inc_count;
    tick();
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("t2_req_%0d", i), ifa.mem_req, 1);
      chk($sformatf("t2_addr_%0d", i), ifa.mem_addr, 1501);
      tick();
    end
    chk("t2_inc", ifa.pc_inc, 1);
    repeat (4) tick();
    chk("t2_valid_hold", ifa.instr_valid, 1);
    chk("t2_one_inc", inc_count - incs0, 1);

    // 3: jump and ready together in VALID
    ifa.jump_req = 1'b1; ifa.jump_target = 16'd6502; ifa.instr_ready = 1'b1; delay_mode = 0;
    tick();
    chk("t3_bus_out", ifa.bus_out, 6502);
    chk("t3_bus_en", ifa.bus_en, 1);
    chk("t3_load_bar", ifa.pc_load_bar, 0);
    chk("t3_jack", ifa.jump_ack, 1);
    chk("t3_no_xfer", ifa.instr_valid, 0);
    ifa.instr_ready = 1'b0;
    tick();
    chk("t3_jack_pulse", ifa.jump_ack, 0);
    tick();
    chk("t3_addr", ifa.mem_addr, 6502);

    // 4: jump requested during WAIT
    delay_mode = 2;
    tick(); tick();
    ifa.instr_ready = 1'b1;
    tick();
    ifa.instr_ready = 1'b0;
    tick();
    chk("t4_in_wait", ifa.mem_req, 1);
    ifa.jump_req = 1'b1; ifa.jump_target = 16'h1234;
    jc0 = jack_count; inc_at = -1; ack_at = -1;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (ifa.pc_inc === 1'b1 && inc_at < 0) inc_at = i;
      if (ifa.jump_ack === 1'b1 && ack_at < 0) ack_at = i;
    end
    chk("t4_inc_at", inc_at, 2);
    chk("t4_ack_at", ack_at, 4);
    chk("t4_one_ack", jack_count - jc0, 1);

    // 5: timeout on the TIMEOUT=4 instance
    tick();
    reset_bar_b = 1'b1;
    tick();
    chk("t5_req", ifb.mem_req, 1);
    repeat (3) tick();
    chk("t5_no_fault_yet", ifb.fault, 0);
    tick();
    chk("t5_fault", ifb.fault, 1);
    chk("t5_req_drop", ifb.mem_req, 0);
    repeat (5) tick();
    chk("t5_fault_sticky", {ifb.fault, ifb.mem_req, ifb.pc_inc, ifb.pc_load_bar}, 4'b1001);
    reset_bar_b = 1'b0;
    tick();
    chk("t5_fault_clr", ifb.fault, 0);
    reset_bar_b = 1'b1;
    tick();
    chk("t5_refetch", {ifb.mem_req, ifb.mem_addr}, {1'b1, 16'h0100});

    // 6: address wrap and reset mid-WAIT
    reset_bar = 1'b0; ifa.jump_req = 1'b0; ifa.pc_value = 16'hFFFF; delay_mode = 0;
    tick();
    reset_bar = 1'b1; ifa.instr_ready = 1'b1;
    tick();
    chk("t6_addr_ffff", ifa.mem_addr, 16'hFFFF);
    repeat (4) tick();
    chk("t6_addr_0", {ifa.mem_req, ifa.mem_addr}, {1'b1, 16'h0000});
    delay_mode = 3;
    repeat (4) tick();
    chk("t6_in_wait", ifa.mem_req, 1);
    reset_bar = 1'b0;
    incs0 = inc_count;
    tick();
    chk("t6_rst_req", ifa.mem_req, 0);
    chk("t6_rst_inc", ifa.pc_inc, 0);
    reset_bar = 1'b1;
    repeat (2) tick();
    chk("t6_no_inc", inc_count - incs0, 0);

    // randomized traffic
    delay_mode = -1;
    for (int i = 0; i < 3000; i++) begin
      tick();
      ifa.instr_ready = ($urandom_range(0, 3) != 0);
      if (!ifa.jump_req && $urandom_range(0, 9) == 0) begin
        ifa.jump_req = 1'b1;
        ifa.jump_target = W'($urandom);
      end
      reset_bar = ($urandom_range(0, 299) != 0);
    end
    reset_bar = 1'b1;
    repeat (2) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
